// File: rtl/ball_collision.sv
// rtl/ball_collision.sv - paddle/ball overlap detector with held collision request and bounce cooldown
// Stage 1 registers per-paddle overlap; stage 2 holds the request until the ball moves, then masks re-hits.
module ball_collision #(
  parameter int          BALL_R         = 10,
  parameter int          PADDLE_L_X     = 32,
  parameter int          PADDLE_R_X     = 984,
  parameter int          PADDLE_W       = 8,
  parameter int          PADDLE_HALF_H  = 48,
  parameter int          HOLD_MAX       = 1_600_000,
  parameter int          COOL_MOVES     = 4,
  parameter logic [15:0] HIT_COUNT_INIT = 16'd0
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos,
  input  logic [11:0] paddle_l_y,
  input  logic [11:0] paddle_r_y,
  output logic        collision_det,
  output logic [1:0]  hit_side,
  output logic [15:0] hit_count
);

  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam int MOVE_W = $clog2(COOL_MOVES + 1);

  localparam logic signed [12:0] R  = 13'(BALL_R);
  localparam logic signed [12:0] LX = 13'(PADDLE_L_X);
  localparam logic signed [12:0] RX = 13'(PADDLE_R_X);
  localparam logic signed [12:0] W  = 13'(PADDLE_W);
  localparam logic signed [12:0] H  = 13'(PADDLE_HALF_H);

  typedef enum logic [1:0] {IDLE, HIT, COOL} state_t;

  state_t             state;
  logic signed [12:0] xs, ys, pls, prs;
  logic               hit_l, hit_r;
  logic               ovl_l, ovl_r;
  logic [11:0]        y_hit, y_prev;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [MOVE_W-1:0]  move_cnt;
  logic               moved;

  // Zero-extended signed operands keep edges near 0 from wrapping to huge values.
  assign xs  = $signed({1'b0, x_pos});
  assign ys  = $signed({1'b0, y_pos});
  assign pls = $signed({1'b0, paddle_l_y});
  assign prs = $signed({1'b0, paddle_r_y});

  assign hit_l = (xs - R <= LX + W) && (xs + R >= LX) &&
                 (ys + R >= pls - H) && (ys - R <= pls + H);
  assign hit_r = (xs + R >= RX) && (xs - R <= RX + W) &&
                 (ys + R >= prs - H) && (ys - R <= prs + H);

  assign moved = (y_pos != y_prev);

  always_ff @(posedge pclk) begin
    if (reset) begin
      ovl_l  <= 1'b0;
      ovl_r  <= 1'b0;
      y_prev <= '0;
    end else begin
      ovl_l  <= hit_l;
      ovl_r  <= hit_r;
      y_prev <= y_pos;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state         <= IDLE;
      collision_det <= 1'b0;
      hit_side      <= 2'b00;
      hit_count     <= HIT_COUNT_INIT;
      y_hit         <= '0;
      hold_cnt      <= '0;
      move_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ovl_l || ovl_r) begin
            state         <= HIT;
            collision_det <= 1'b1;
            hit_side      <= ovl_l ? 2'b01 : 2'b10;
            hit_count     <= hit_count + 16'd1;
            y_hit         <= y_pos;
            hold_cnt      <= '0;
          end
        end
        HIT: begin
          // The motion logic only samples on movement ticks, so hold until it reacts.
          if (y_pos != y_hit || hold_cnt == HOLD_W'(HOLD_MAX - 1)) begin
            state         <= COOL;
            collision_det <= 1'b0;
            hit_side      <= 2'b00;
            move_cnt      <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        COOL: begin
          if (!ovl_l && !ovl_r) begin
            state <= IDLE;
          end else if (moved) begin
            if (move_cnt == MOVE_W'(COOL_MOVES - 1)) state <= IDLE;
            else move_cnt <= move_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_collision.sv
// tb/tb_ball_collision.sv - scoreboard bench for ball_collision with a behavioural reference model
module tb_ball_collision;

  localparam int BALL_R = 10;
  localparam int LX     = 32;
  localparam int RX     = 40;
  localparam int PW     = 8;
  localparam int PH     = 48;
  localparam int HOLD   = 16;
  localparam int COOLN  = 4;

  logic        pclk  = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] x_pos = 12'd45;
  logic [11:0] y_pos = 12'd300;
  logic [11:0] paddle_l_y = 12'd300;
  logic [11:0] paddle_r_y = 12'd700;
  logic        collision_det, collision_det_w;
  logic [1:0]  hit_side, hit_side_w;
  logic [15:0] hit_count, hit_count_w;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  ball_collision #(.PADDLE_R_X(RX), .HOLD_MAX(HOLD)) dut (
    .pclk(pclk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .collision_det(collision_det), .hit_side(hit_side), .hit_count(hit_count)
  );

  ball_collision #(.PADDLE_R_X(RX), .HOLD_MAX(HOLD), .HIT_COUNT_INIT(16'hFFFF)) dut_wrap (
    .pclk(pclk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .collision_det(collision_det_w), .hit_side(hit_side_w), .hit_count(hit_count_w)
  );

  typedef struct packed {
    logic        det;
    logic [1:0]  side;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit touches(input int x, input int y, input int px, input int py);
    return (x - BALL_R <= px + PW) && (x + BALL_R >= px) &&
           (y + BALL_R >= py - PH) && (y - BALL_R <= py + PH);
  endfunction

  // Reference model: mode 0 = armed, 1 = requesting, 2 = cooling down.
  int   m_mode, m_age, m_moves, m_yhit, m_ylast, m_side, m_cnt;
  bit   m_pl, m_pr, m_det;
  int   mx, my;
  exp_t m_e, mon_e;

  always @(posedge pclk) begin
    mx = int'(x_pos);
    my = int'(y_pos);
    if (reset) begin
      m_mode = 0; m_det = 0; m_side = 0; m_cnt = 0;
      m_pl = 0; m_pr = 0; m_age = 0; m_moves = 0; m_yhit = 0;
    end else begin
      if (m_mode == 0) begin
        if (m_pl || m_pr) begin
          m_mode = 1; m_det = 1; m_side = m_pl ? 1 : 2;
          m_cnt = (m_cnt + 1) % 65536; m_yhit = my; m_age = 0;
        end
      end else if (m_mode == 1) begin
        if (my != m_yhit || m_age == HOLD - 1) begin
          m_mode = 2; m_det = 0; m_side = 0; m_moves = 0;
        end else begin
          m_age++;
        end
      end else begin
        if (my != m_ylast) m_moves++;
        if ((!m_pl && !m_pr) || m_moves >= COOLN) m_mode = 0;
      end
      m_pl = touches(mx, my, LX, int'(paddle_l_y));
      m_pr = touches(mx, my, RX, int'(paddle_r_y));
    end
    m_ylast = my;
    m_e.det  = m_det;
    m_e.side = 2'(m_side);
    m_e.cnt  = 16'(m_cnt);
    sb_q.push_back(m_e);
  end

  always @(negedge pclk) begin
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      mon_e = sb_q.pop_front();
      check("collision_det", collision_det, mon_e.det);
      check("hit_side", hit_side, mon_e.side);
      check("hit_count", hit_count, mon_e.cnt);
      check("wrap_det", collision_det_w, mon_e.det);
      check("wrap_count", hit_count_w, 32'((int'(mon_e.cnt) + 65535) % 65536));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic clear_field();
    x_pos = 12'd200;
    y_pos = 12'd400;
    cycles(25);
  endtask

  task automatic place(input int x, input int y, input int pl, input int pr);
    x_pos = 12'(x); y_pos = 12'(y); paddle_l_y = 12'(pl); paddle_r_y = 12'(pr);
  endtask

  int high;
  int yi;

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("reset_det", collision_det, 0);
      check("reset_count", hit_count, 0);
    end
    reset = 1'b0;
    @(negedge pclk);
    check("det_plus1", collision_det, 0);
    @(negedge pclk);
    check("det_plus2", collision_det, 1);
    check("left_side", hit_side, 1);
    check("first_count", hit_count, 1);
    check("wrap_to_zero", hit_count_w, 0);

    y_pos = 12'd298;
    @(negedge pclk);
    check("release", collision_det, 0);
    x_pos = 12'd200;
    cycles(4);
    x_pos = 12'd45;
    cycles(3);
    check("second_hit", hit_count, 2);

    clear_field();
    place(45, 242, 300, 700);
    cycles(3);
    check("exact_touch", collision_det, 1);
    clear_field();
    place(45, 241, 300, 700);
    cycles(4);
    check("below_edge", collision_det, 0);
    clear_field();
    place(45, 5, 20, 700);
    cycles(3);
    check("near_zero", collision_det, 1);

    clear_field();
    place(45, 300, 300, 700);
    high = 0;
    repeat (30) begin
      @(negedge pclk);
      if (collision_det) high++;
    end
    check("timeout_width", high, HOLD);
    for (int k = 1; k <= 3; k++) begin
      y_pos = 12'(300 + k);
      repeat (2) begin
        @(negedge pclk);
        check("cool_masked", collision_det, 0);
      end
    end
    y_pos = 12'd304;
    cycles(2);
    check("rearm_4th", collision_det, 1);

    clear_field();
    place(45, 300, 300, 300);
    cycles(3);
    check("both_left_wins", hit_side, 1);
    clear_field();
    place(55, 300, 700, 300);
    cycles(3);
    check("right_only", hit_side, 2);
    cycles(2);
    reset = 1'b1;
    @(negedge pclk);
    check("reset_in_hit", collision_det, 0);
    check("reset_in_hit_side", hit_side, 0);
    reset = 1'b0;
    cycles(3);

    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 1) != 0) x_pos = 12'($urandom_range(22, 60));
      else x_pos = 12'($urandom_range(0, 1023));
      paddle_l_y = 12'($urandom_range(0, 767));
      paddle_r_y = 12'($urandom_range(0, 767));
      yi = ($urandom_range(0, 1) != 0) ? int'(paddle_l_y) : int'(paddle_r_y);
      yi = yi + int'($urandom_range(0, 140)) - 70;
      if (yi < 0) yi = 0;
      if (yi > 767) yi = 767;
      y_pos = 12'(yi);
      reset = ($urandom_range(0, 199) == 0);
      cycles(int'($urandom_range(1, 4)));
    end
    reset = 1'b0;
    cycles(3);
    @(posedge pclk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
